xor_scheduler: RTL and testbench
================================

XOR_SCHEDULER -- requirements
Module: xor_scheduler

Interface
REQ-001 Parameter W, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 request; held high until ack0.
REQ-005 a0  input  W  requester 0 operand A; stable while req0 high.
REQ-006 b0  input  W  requester 0 operand B; stable while req0 high.
REQ-007 req1  input  1  requester 1 request; same rules as req0.
REQ-008 a1  input  W  requester 1 operand A.
REQ-009 b1  input  W  requester 1 operand B.
REQ-010 ack0  output  1  one-cycle pulse: requester 0 operands captured.
REQ-011 ack1  output  1  one-cycle pulse: requester 1 operands captured.
REQ-012 busy  output  1  high in RUN and DONE states.
REQ-013 done  output  1  one-cycle pulse: r valid for a newly finished operation.
REQ-014 done_id  output  1  requester served by the current/last operation.
REQ-015 r  output  W  result a XOR b; holds value until the next done.

Function
REQ-016 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE: on an edge with any req high, capture winner's a/b into shift registers, clear bit counter, set done_id to winner, go RUN; ack of winner high the following cycle only.
REQ-018 Arbitration: only one request high -> it wins; both high -> requester not served last wins; after reset requester 0 has priority.
REQ-019 Requests sampled only in IDLE; req high during RUN/DONE is ignored until IDLE (no ack, no loss).
REQ-020 RUN: each cycle one bit pair (LSB first) passes through the single shared 1-bit XOR cell; result bit shifts into result register from MSB side; operand registers shift right.
REQ-021 RUN lasts exactly W cycles (counter 0..W-1, width ceil(log2 W)); at count W-1 go DONE.
REQ-022 DONE: r <= completed result register, done high one cycle, last-served pointer <= done_id, go IDLE.
REQ-023 Latency: capture edge to done-high cycle = W+1 cycles; minimum spacing between consecutive acks = W+2 cycles.
REQ-024 r, done_id unchanged except at DONE/capture respectively; busy low in IDLE.
REQ-025 Persistent requests from both sides are served strictly alternately.
REQ-026 Operand bits are never combined across requesters; a request is served only once per ack.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, ack0=ack1=0, busy=0, done=0, done_id=0, r=0, counter=0, shift registers=0, last-served pointer = requester 1 (so requester 0 wins first tie).
REQ-028 Reset during RUN/DONE aborts the operation: no done, no r update; the requester must keep req high and is re-arbitrated after release.
REQ-029 First capture possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package/include xor_sched_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default W.
REQ-031 One sub-module xor_nand_cell (inputs x,y; output r) implements 1-bit XOR from four 2-input NANDs; the scheduler instantiates exactly one, no other XOR logic in the datapath.
REQ-032 Unused state encoding 2'd3 returns to IDLE on the next edge.

Verification
REQ-033 W=8, req0 with a0=8'hA5, b0=8'h3C -> ack0 one cycle later, done after 9 cycles from capture, r=8'h99, done_id=0.
REQ-034 After reset both req high (a0^b0=8'h0F, a1^b1=8'hF0) -> req0 served first (r=8'h0F), then req1 (r=8'hF0), acks 10 cycles apart.
REQ-035 Both requesters held high for 4 operations -> done_id sequence 0,1,0,1.
REQ-036 a=b=8'hFF -> r=8'h00; a=8'hFF, b=8'h00 -> r=8'hFF.
REQ-037 rst_n pulsed low at RUN cycle 4 -> busy=0, no done, r=0; after release same request re-served, correct result.
REQ-038 xor_nand_cell exhaustive: 00->0, 01->1, 10->1, 11->0.

Source files
------------

// File: rtl/xor_sched_pkg.sv
// xor_sched_pkg: state encoding and default width for the bit-serial xor scheduler
package xor_sched_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/xor_nand_cell.sv
// xor_nand_cell: 1-bit xor built from four 2-input nands
module xor_nand_cell (
  input  logic x,
  input  logic y,
  output logic r
);
  logic n1, n2, n3;
  assign n1 = ~(x & y);
  assign n2 = ~(x & n1);
  assign n3 = ~(y & n1);
  assign r  = ~(n2 & n3);
endmodule

// File: rtl/xor_scheduler.sv
// xor_scheduler: two-requester arbiter feeding one shared 1-bit xor cell, LSB first over W cycles
module xor_scheduler
  import xor_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] r
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t st, nxt;
  logic [W-1:0] sa, sb, acc;
  logic [CW-1:0] cnt;
  logic last, win, xb, take;
  // ties go to whoever was not served last; last resets to 1 so requester 0 wins first
  assign win  = (req0 & req1) ? ~last : req1;
  assign take = (st == IDLE) & (req0 | req1);
  xor_nand_cell u_xor (.x(sa[0]), .y(sb[0]), .r(xb));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb
    nxt = (st == IDLE) ? ((req0 | req1) ? RUN : IDLE)
        : (st == RUN)  ? ((cnt == LAST) ? DONE : RUN)
        : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      r       <= '0;
      sa      <= '0;
      sb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      ack0 <= take & ~win;
      ack1 <= take & win;
      busy <= nxt != IDLE;
      done <= st == DONE;
      if (take) begin
        sa      <= win ? a1 : a0;
        sb      <= win ? b1 : b0;
        cnt     <= '0;
        done_id <= win;
      end
      // result bits enter at the MSB so the first (LSB) bit lands at bit 0 after W shifts
      if (st == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        acc <= {xb, acc[W-1:1]};
        cnt <= cnt + 1'b1;
      end
      if (st == DONE) begin
        r    <= acc;
        last <= done_id;
      end
    end
endmodule

// File: tb/tb_xor_scheduler.sv
// tb_xor_scheduler: table-driven vectors with a done-side scoreboard, plus reset and persistent-request sequences
module tb_xor_scheduler;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, busy, done, done_id;
  logic [W-1:0] r;
  logic cx = 0, cy = 0, cr;
  int vecs = 0, miss = 0, cyc = 0, ack_cyc = 0;
  logic m_last = 1'b1;
  typedef struct {logic id; logic [W-1:0] r;} exp_t;
  typedef struct {logic rq0, rq1; logic [W-1:0] a0, b0, a1, b1, e0, e1;} vec_t;
  exp_t sbq[$];
  exp_t em;
  vec_t tbl[7];
  logic nand_exp[4];

  xor_scheduler #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .done(done), .done_id(done_id), .r(r)
  );
  xor_nand_cell u_cell (.x(cx), .y(cy), .r(cr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] v);
    exp_t e;
    e.id = id;
    e.r  = v;
    sbq.push_back(e);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (ack0 | ack1) begin
      chk("ack_exclusive", {31'd0, ack0 & ack1}, 0);
      chk("busy_on_ack", {31'd0, busy}, 1);
      chk("ack_pulse", (cyc - ack_cyc > 1) ? 1 : 0, 1);
      ack_cyc = cyc;
    end
    if (done) begin
      chk("done_latency", cyc - ack_cyc, W + 1);
      chk("busy_on_done", {31'd0, busy}, 0);
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        em = sbq.pop_front();
        chk("r", {24'd0, r}, {24'd0, em.r});
        chk("done_id", {31'd0, done_id}, {31'd0, em.id});
      end
    end
  end

  task automatic wait_all(input int bound);
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
      if (!req0 && !req1 && sbq.size() == 0) break;
    end
    chk("op_complete", (req0 || req1 || sbq.size() != 0) ? 1 : 0, 0);
  endtask

  task automatic apply(input vec_t v);
    int c0, c1;
    logic f;
    c0 = -1;
    c1 = -1;
    f = (v.rq0 & v.rq1) ? ~m_last : v.rq1;
    push(f, f ? v.e1 : v.e0);
    if (v.rq0 & v.rq1) push(~f, f ? v.e0 : v.e1);
    m_last = (v.rq0 & v.rq1) ? ~f : f;
    @(negedge clk);
    req0 = v.rq0; a0 = v.a0; b0 = v.b0;
    req1 = v.rq1; a1 = v.a1; b1 = v.b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (ack0) begin req0 = 0; c0 = cyc; end
      if (ack1) begin req1 = 0; c1 = cyc; end
      if (!req0 && !req1 && sbq.size() == 0) break;
    end
    chk("vec_complete", (req0 || req1 || sbq.size() != 0) ? 1 : 0, 0);
    if (v.rq0 & v.rq1) chk("ack_spacing", (c1 > c0) ? c1 - c0 : c0 - c1, W + 2);
  endtask

  initial begin
    int n0, n1, pa;
    tbl[0] = '{1'b1, 1'b1, 8'h3C, 8'h33, 8'hAA, 8'h5A, 8'h0F, 8'hF0};
    tbl[1] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h99, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'h01, 8'h80, 8'h12, 8'h34, 8'h81, 8'h26};
    tbl[3] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00, 8'hC3};
    tbl[6] = '{1'b1, 1'b1, 8'h55, 8'hAA, 8'hC3, 8'hC3, 8'hFF, 8'h00};
    nand_exp = '{1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) begin
      cx = i[1];
      cy = i[0];
      #1;
      chk("nand_cell", {31'd0, cr}, {31'd0, nand_exp[i]});
    end

    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_done_id", {31'd0, done_id}, 0);
    chk("rst_r", {24'd0, r}, 0);
    rst_n = 1;

    foreach (tbl[i]) apply(tbl[i]);

    // both requesters persistently high: four operations, strictly alternating
    n0 = 0; n1 = 0; pa = -1;
    push(~m_last, m_last ? 8'h3C : 8'h5A);
    push(m_last, m_last ? 8'h5A : 8'h3C);
    push(~m_last, m_last ? 8'h3C : 8'h5A);
    push(m_last, m_last ? 8'h5A : 8'h3C);
    @(negedge clk);
    req0 = 1; a0 = 8'hF0; b0 = 8'hCC;
    req1 = 1; a1 = 8'h0F; b1 = 8'h55;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        if (pa >= 0) chk("persist_spacing", cyc - pa, W + 2);
        pa = cyc;
      end
      if (ack0) begin n0++; if (n0 == 2) req0 = 0; end
      if (ack1) begin n1++; if (n1 == 2) req1 = 0; end
      if (!req0 && !req1 && sbq.size() == 0) break;
    end
    chk("persist_complete", (req0 || req1 || sbq.size() != 0) ? 1 : 0, 0);

    // reset in the middle of RUN aborts; the held request is served again
    @(negedge clk);
    req0 = 1; a0 = 8'hA5; b0 = 8'h3C;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ack0) break;
    end
    chk("abort_ack", {31'd0, ack0}, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_r", {24'd0, r}, 0);
    chk("abort_done_id", {31'd0, done_id}, 0);
    m_last = 1'b1;
    push(1'b0, 8'h99);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("first_capture", {31'd0, ack0}, 1);
    req0 = 0;
    wait_all(40);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
